if_fetch: RTL and testbench

//  Instruction fetch stage: owns the PC and drives the instruction ROM read port.

---
 rtl/if_fetch_if.sv | 29 ++
 rtl/if_fetch.sv | 135 +++++++++++++
 tb/tb_if_fetch.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_if.sv
// Fetch-stage signal bundle: ROM read port, redirect from EX, and the IF/ID hand-off.
interface if_fetch_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0] rom_addr;
  logic          rom_cs;
  logic          rom_we;
  logic [3:0]    rom_wem;
  logic [DW-1:0] rom_data;

  logic          jump_en;
  logic [AW-1:0] jump_addr;

  logic          id_ready;
  logic          if_valid;
  logic [DW-1:0] if_inst;
  logic [AW-1:0] if_instaddr;

  modport master (
    output rom_addr, rom_cs, rom_we, rom_wem, if_valid, if_inst, if_instaddr,
    input  rom_data, jump_en, jump_addr, id_ready
  );

  modport slave (
    input  rom_addr, rom_cs, rom_we, rom_wem, if_valid, if_inst, if_instaddr,
    output rom_data, jump_en, jump_addr, id_ready
  );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch: owns the PC, issues one ROM read per cycle, registers the word for decode,
// absorbs one in-flight word in a skid entry under decode back-pressure, and squashes on redirect.
//
//   state | meaning
//   BOOT  | first cycle after reset, no fetch issued, jumps ignored
//   RUN   | skid empty, a read is issued every cycle unless a response is being parked
//   SKID  | skid holds one word, issue paused until decode frees the output register
module if_fetch #(
  parameter int            AW       = 32,
  parameter int            DW       = 32,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter logic [DW-1:0] NOP_INST = DW'(32'h0000_0013)
) (
  input logic        clk,
  input logic        rst_n,
  if_fetch_if.master bus
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_SKID = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          pend_q;
  logic [AW-1:0] req_addr_q;
  logic [DW-1:0] skid_inst_q;
  logic [AW-1:0] skid_addr_q;
  logic          out_valid_q;
  logic [DW-1:0] out_inst_q;
  logic [AW-1:0] out_addr_q;

  logic          rom_cs;
  logic [AW-1:0] rom_addr;
  logic          jump;
  logic          blocked;
  logic          skid_full;
  logic [AW-1:0] jump_tgt;

  assign jump_tgt  = bus.jump_addr & ~{{(AW-2){1'b0}}, 2'b11};
  assign jump      = bus.jump_en & (state_q != ST_BOOT);
  assign blocked   = out_valid_q & ~bus.id_ready;
  assign skid_full = (state_q == ST_SKID);

  // A read is issued only when its response is sure to find room one cycle later, so the
  // cycle that parks a word stops issue, and the cycle that drains the skid resumes it.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    rom_cs   = 1'b0;
    rom_addr = pc_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (pend_q && blocked) begin
          state_d = ST_SKID;
        end else begin
          rom_cs = 1'b1;
          pc_d   = pc_q + AW'(4);
        end
      end
      ST_SKID: begin
        if (bus.id_ready) begin
          state_d = ST_RUN;
          rom_cs  = 1'b1;
          pc_d    = pc_q + AW'(4);
        end
      end
      default: state_d = ST_BOOT;
    endcase
    if (jump) begin
      state_d  = ST_RUN;
      rom_cs   = 1'b1;
      rom_addr = jump_tgt;
      pc_d     = jump_tgt + AW'(4);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // The skid entry is older than any response in flight, so it wins the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q      <= 1'b0;
      req_addr_q  <= '0;
      skid_inst_q <= NOP_INST;
      skid_addr_q <= '0;
      out_valid_q <= 1'b0;
      out_inst_q  <= NOP_INST;
      out_addr_q  <= '0;
    end else begin
      pend_q     <= rom_cs;
      req_addr_q <= rom_addr;
      if (jump) begin
        out_valid_q <= 1'b0;
        out_inst_q  <= NOP_INST;
      end else if (!blocked) begin
        if (skid_full) begin
          out_valid_q <= 1'b1;
          out_inst_q  <= skid_inst_q;
          out_addr_q  <= skid_addr_q;
        end else if (pend_q) begin
          out_valid_q <= 1'b1;
          out_inst_q  <= bus.rom_data;
          out_addr_q  <= req_addr_q;
        end else begin
          out_valid_q <= 1'b0;
          out_inst_q  <= NOP_INST;
        end
      end else if (pend_q) begin
        skid_inst_q <= bus.rom_data;
        skid_addr_q <= req_addr_q;
      end
    end
  end

  assign bus.rom_cs      = rom_cs;
  assign bus.rom_addr    = rom_addr;
  assign bus.rom_we      = 1'b0;
  assign bus.rom_wem     = 4'b0000;
  assign bus.if_valid    = out_valid_q;
  assign bus.if_inst     = out_inst_q;
  assign bus.if_instaddr = out_addr_q;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: cycle-exact directed vector table, reset-pulse sequence, then random
// ready/jump traffic checked against an in-order instruction-stream scoreboard.
module tb_if_fetch;
  localparam int          AW  = 32;
  localparam int          DW  = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int          NV  = 22;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  if_fetch_if #(.AW(AW), .DW(DW)) bus ();

  if_fetch #(.AW(AW), .DW(DW), .RESET_PC(32'h0), .NOP_INST(NOP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        ready;
    logic        jump;
    logic [31:0] jaddr;
    logic        cs;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] iaddr;
  } vec_t;

  vec_t tbl [NV];

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic setv(input int i, input logic r, input logic j, input logic [31:0] ja,
                      input logic cs, input logic [31:0] a, input logic v, input logic [31:0] ia);
    tbl[i] = '{r, j, ja, cs, a, v, ia};
  endtask

  // Registered ROM: data for the address presented with rom_cs appears after the edge.
  task automatic tick();
    logic        cs;
    logic [31:0] a;
    cs = bus.rom_cs;
    a  = bus.rom_addr;
    @(posedge clk);
    #1;
    bus.rom_data = cs ? rom_word(a) : 32'hBAD0_BAD0;
  endtask

  task automatic drive(input logic r, input logic j, input logic [31:0] ja);
    bus.id_ready  = r;
    bus.jump_en   = j;
    bus.jump_addr = ja;
    #1;
  endtask

  initial begin
    logic [31:0] exp_pc;
    int          age;
    int          accepted;
    logic        j;
    logic        rdy;
    logic [31:0] ja;

    //      ready jump jaddr         cs   addr          valid iaddr
    setv( 0, 1, 1, 32'h0000_0200, 0, 32'h0,         0, 32'h0);
    setv( 1, 1, 0, 32'h0,         1, 32'h0000_0000, 0, 32'h0);
    setv( 2, 1, 0, 32'h0,         1, 32'h0000_0004, 0, 32'h0);
    setv( 3, 1, 0, 32'h0,         1, 32'h0000_0008, 1, 32'h0000_0000);
    setv( 4, 1, 0, 32'h0,         1, 32'h0000_000C, 1, 32'h0000_0004);
    setv( 5, 1, 0, 32'h0,         1, 32'h0000_0010, 1, 32'h0000_0008);
    setv( 6, 1, 0, 32'h0,         1, 32'h0000_0014, 1, 32'h0000_000C);
    setv( 7, 0, 0, 32'h0,         0, 32'h0,         1, 32'h0000_0010);
    setv( 8, 0, 0, 32'h0,         0, 32'h0,         1, 32'h0000_0010);
    setv( 9, 0, 0, 32'h0,         0, 32'h0,         1, 32'h0000_0010);
    setv(10, 1, 0, 32'h0,         1, 32'h0000_0018, 1, 32'h0000_0010);
    setv(11, 1, 0, 32'h0,         1, 32'h0000_001C, 1, 32'h0000_0014);
    setv(12, 1, 0, 32'h0,         1, 32'h0000_0020, 1, 32'h0000_0018);
    setv(13, 1, 1, 32'h0000_0103, 1, 32'h0000_0100, 1, 32'h0000_001C);
    setv(14, 1, 0, 32'h0,         1, 32'h0000_0104, 0, 32'h0);
    setv(15, 1, 0, 32'h0,         1, 32'h0000_0108, 1, 32'h0000_0100);
    setv(16, 0, 0, 32'h0,         0, 32'h0,         1, 32'h0000_0104);
    setv(17, 0, 0, 32'h0,         0, 32'h0,         1, 32'h0000_0104);
    setv(18, 0, 1, 32'hFFFF_FFFE, 1, 32'hFFFF_FFFC, 1, 32'h0000_0104);
    setv(19, 1, 0, 32'h0,         1, 32'h0000_0000, 0, 32'h0);
    setv(20, 1, 0, 32'h0,         1, 32'h0000_0004, 1, 32'hFFFF_FFFC);
    setv(21, 1, 0, 32'h0,         1, 32'h0000_0008, 1, 32'h0000_0000);

    bus.rom_data  = 32'h0;
    bus.id_ready  = 1'b0;
    bus.jump_en   = 1'b0;
    bus.jump_addr = 32'h0;
    rst_n         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset valid",    32'(bus.if_valid), 32'h0);
    check("reset inst",     bus.if_inst,       NOP);
    check("reset instaddr", bus.if_instaddr,   32'h0);
    check("reset cs",       32'(bus.rom_cs),   32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].ready, tbl[i].jump, tbl[i].jaddr);
      check($sformatf("vec%0d cs", i), 32'(bus.rom_cs), 32'(tbl[i].cs));
      if (tbl[i].cs)
        check($sformatf("vec%0d rom_addr", i), bus.rom_addr, tbl[i].addr);
      check($sformatf("vec%0d valid", i), 32'(bus.if_valid), 32'(tbl[i].valid));
      if (tbl[i].valid) begin
        check($sformatf("vec%0d instaddr", i), bus.if_instaddr, tbl[i].iaddr);
        check($sformatf("vec%0d inst", i), bus.if_inst, rom_word(tbl[i].iaddr));
      end else begin
        check($sformatf("vec%0d nop", i), bus.if_inst, NOP);
      end
      check($sformatf("vec%0d we", i), {27'h0, bus.rom_we, bus.rom_wem}, 32'h0);
      tick();
    end

    // Reset pulse mid-stream: outputs clear without a clock edge, then refetch from RESET_PC.
    drive(1'b1, 1'b0, 32'h0);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst valid",    32'(bus.if_valid), 32'h0);
    check("midrst inst",     bus.if_inst,       NOP);
    check("midrst instaddr", bus.if_instaddr,   32'h0);
    check("midrst cs",       32'(bus.rom_cs),   32'h0);
    tick();
    rst_n = 1'b1;
    #1;
    check("boot cs", 32'(bus.rom_cs), 32'h0);
    tick();
    #1;
    check("refetch cs0",   32'(bus.rom_cs), 32'h1);
    check("refetch addr0", bus.rom_addr,    32'h0);
    tick();
    #1;
    check("refetch addr1", bus.rom_addr,    32'h4);
    check("refetch v1",    32'(bus.if_valid), 32'h0);
    tick();
    #1;
    check("refetch v2",    32'(bus.if_valid), 32'h1);
    check("refetch ia2",   bus.if_instaddr,   32'h0);
    check("refetch inst2", bus.if_inst,       rom_word(32'h0));
    tick();

    // Random traffic: every accepted instruction must be the next one in program order.
    exp_pc   = 32'h0;
    age      = 0;
    accepted = 0;
    for (int n = 0; n < 3000; n++) begin
      j   = (n == 0) || ($urandom_range(0, 19) == 0);
      ja  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | ($urandom & 32'h1F)) : $urandom;
      rdy = ($urandom_range(0, 3) != 0);
      drive(rdy, j, ja);
      if (j) begin
        check("rnd jump cs",   32'(bus.rom_cs), 32'h1);
        check("rnd jump addr", bus.rom_addr,    ja & ~32'h3);
      end
      if (!bus.if_valid)
        check("rnd nop", bus.if_inst, NOP);
      if (age >= 2)
        check("rnd gap", 32'(bus.if_valid), 32'h1);
      if (bus.if_valid && rdy && !j) begin
        check("rnd order", bus.if_instaddr, exp_pc);
        check("rnd data",  bus.if_inst,     rom_word(exp_pc));
        exp_pc = exp_pc + 32'h4;
        accepted++;
      end
      if (j) begin
        exp_pc = ja & ~32'h3;
        age    = 0;
      end else begin
        age++;
      end
      tick();
    end
    check("rnd throughput", 32'(accepted >= 1200), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
